// File: rtl/load_access_sequencer.sv
// load_access_sequencer: multicycle RV32 load unit that decodes and legality-checks one load,
// issues a single word-aligned bus read and returns the lane-extracted, extended result.
module load_access_sequencer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_funct3,
    input  logic        req_amo,
    input  logic [31:0] req_addr,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_misaligned,
    output logic        rsp_illegal,
    output logic        rsp_timeout,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);
    state_t            state_q, state_d;
    logic [2:0]        f3_q, f3_d;
    logic [31:0]       addr_q, addr_d, data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mis_q, mis_d, ill_q, ill_d, to_q, to_d;
    logic [2:0]        f3_in;
    logic              ill_in, mis_in, timed_out;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [31:0]       ext;
    // AMO loads are always word loads, so they bypass the funct3 legality check
    assign f3_in     = req_amo ? 3'b010 : req_funct3;
    assign ill_in    = (f3_in[1:0] == 2'b11) || (f3_in[2:1] == 2'b11);
    assign mis_in    = (f3_in[0] & req_addr[0]) | (f3_in[1] & |req_addr[1:0]);
    assign lane_b    = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign lane_h    = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    assign ext       = f3_q[1] ? mem_rdata :
                       f3_q[0] ? {{16{~f3_q[2] & lane_h[15]}}, lane_h} :
                                 {{24{~f3_q[2] & lane_b[7]}}, lane_b};
    assign timed_out = (TIMEOUT_CYCLES != 0) && (cnt_q == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            f3_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
            ill_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
            ill_q   <= ill_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;
        ill_d   = ill_q;
        to_d    = to_q;
        case (state_q)
            IDLE: if (req_valid) begin
                f3_d   = f3_in;
                addr_d = req_addr;
                cnt_d  = '0;
                if (ill_in || mis_in) begin
                    state_d = RESP;
                    data_d  = '0;
                    ill_d   = ill_in;
                    mis_d   = ~ill_in & mis_in;
                    to_d    = 1'b0;
                end else begin
                    state_d = REQ;
                end
            end
            REQ: if (mem_ready) begin
                state_d = RESP;
                data_d  = ext;
                {mis_d, ill_d, to_d} = 3'b000;
            end else if (timed_out) begin
                state_d = RESP;
                data_d  = '0;
                {mis_d, ill_d, to_d} = 3'b001;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready      = state_q == IDLE;
        busy           = state_q != IDLE;
        mem_valid      = state_q == REQ;
        rsp_valid      = state_q == RESP;
        mem_addr       = {addr_q[31:2], 2'b00};
        rsp_data       = data_q;
        rsp_misaligned = mis_q;
        rsp_illegal    = ill_q;
        rsp_timeout    = to_q;
    end
endmodule

// File: tb/tb_load_access_sequencer.sv
// tb_load_access_sequencer: table-driven loads with a response scoreboard, plus reset corner cases.
module tb_load_access_sequencer;
    localparam int T = 8;
    logic        clk = 1'b0, reset = 1'b1;
    logic        req_valid = 1'b0, req_amo = 1'b0, mem_ready = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0, mem_rdata = '0;
    logic        req_ready, mem_valid, rsp_valid, rsp_misaligned, rsp_illegal, rsp_timeout, busy;
    logic [31:0] mem_addr, rsp_data;
    int checks = 0, errors = 0;

    load_access_sequencer #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_funct3(req_funct3), .req_amo(req_amo), .req_addr(req_addr),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_misaligned(rsp_misaligned),
        .rsp_illegal(rsp_illegal), .rsp_timeout(rsp_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    // flags are {timeout, illegal, misaligned}
    typedef struct {
        logic [2:0]  f3;
        logic        amo;
        logic [31:0] addr;
        logic [31:0] rdata;
        int          waits;
        logic [31:0] data;
        logic [2:0]  flags;
    } vec_t;
    typedef struct {
        logic [31:0] data;
        logic [2:0]  flags;
        int          lat;
        int          mv;
    } exp_t;
    exp_t sb[$];
    vec_t vecs[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input vec_t v);
        exp_t e, x;
        int lat, mv;
        bit done;
        lat = 0; mv = 0; done = 0;
        e.data  = v.data;
        e.flags = v.flags;
        e.mv    = v.flags[2] ? T : (v.flags[1:0] != 0) ? 0 : v.waits + 1;
        e.lat   = (v.flags[1:0] != 0) ? 1 : v.flags[2] ? T + 1 : v.waits + 2;
        check("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_funct3 = v.f3; req_amo = v.amo; req_addr = v.addr; mem_rdata = v.rdata;
        sb.push_back(e);
        tick;
        req_valid = 1'b0;
        lat = 1;
        while (!done && lat < 60) begin
            if (rsp_valid) begin
                done = 1;
                if (sb.size() == 0) begin
                    check("sb_empty", 64'd1, 64'd0);
                end else begin
                    x = sb.pop_front();
                    check("rsp_data", 64'(rsp_data), 64'(x.data));
                    check("rsp_flags", 64'({rsp_timeout, rsp_illegal, rsp_misaligned}), 64'(x.flags));
                    check("latency", 64'(lat), 64'(x.lat));
                    check("mem_valid_cycles", 64'(mv), 64'(x.mv));
                end
            end else begin
                if (mem_valid) begin
                    mv++;
                    if (mv == 1) check("mem_addr", 64'(mem_addr), 64'({v.addr[31:2], 2'b00}));
                    mem_ready = (mv == v.waits + 1);
                end else begin
                    mem_ready = 1'b0;
                end
                tick;
                lat++;
            end
        end
        mem_ready = 1'b0;
        if (!done) begin
            check("rsp_wait_expired", 64'd0, 64'd1);
            sb.delete();
        end else begin
            tick;
            check("rsp_one_cycle", 64'({rsp_valid, req_ready}), 64'b01);
            check("rsp_data_held", 64'(rsp_data), 64'(x.data));
        end
    endtask

    initial begin
        vecs[0]  = '{3'b000, 1'b0, 32'h0000_1003, 32'h8011_2233, 0,  32'hFFFF_FF80, 3'b000};
        vecs[1]  = '{3'b101, 1'b0, 32'h0000_2002, 32'hBEEF_1234, 3,  32'h0000_BEEF, 3'b000};
        vecs[2]  = '{3'b010, 1'b0, 32'h0000_3001, 32'hFFFF_FFFF, 0,  32'h0,         3'b001};
        vecs[3]  = '{3'b011, 1'b0, 32'h0000_0010, 32'hFFFF_FFFF, 0,  32'h0,         3'b010};
        vecs[4]  = '{3'b000, 1'b1, 32'h0000_4000, 32'h8000_0001, 0,  32'h8000_0001, 3'b000};
        vecs[5]  = '{3'b000, 1'b0, 32'h0000_5000, 32'h1234_5678, 99, 32'h0,         3'b100};
        vecs[6]  = '{3'b010, 1'b0, 32'h0000_6000, 32'hCAFE_F00D, 7,  32'hCAFE_F00D, 3'b000};
        vecs[7]  = '{3'b100, 1'b0, 32'h0000_7001, 32'h1234_A5FF, 1,  32'h0000_00A5, 3'b000};
        vecs[8]  = '{3'b001, 1'b0, 32'h0000_7002, 32'h8001_7FFF, 0,  32'hFFFF_8001, 3'b000};
        vecs[9]  = '{3'b001, 1'b0, 32'h0000_7000, 32'h8001_7FFF, 0,  32'h0000_7FFF, 3'b000};
        vecs[10] = '{3'b001, 1'b0, 32'h0000_7001, 32'h8001_7FFF, 0,  32'h0,         3'b001};
        vecs[11] = '{3'b111, 1'b0, 32'h0000_0001, 32'h0,         0,  32'h0,         3'b010};
        vecs[12] = '{3'b111, 1'b1, 32'h0000_8004, 32'h0000_0055, 0,  32'h0000_0055, 3'b000};
        vecs[13] = '{3'b001, 1'b1, 32'h0000_8002, 32'h0,         0,  32'h0,         3'b001};
        vecs[14] = '{3'b000, 1'b0, 32'h0000_9002, 32'h00FF_0000, 2,  32'hFFFF_FFFF, 3'b000};
        vecs[15] = '{3'b110, 1'b0, 32'h0000_9003, 32'h0,         0,  32'h0,         3'b010};
        #1;
        check("reset_outputs",
              64'({mem_valid, rsp_valid, busy, rsp_misaligned, rsp_illegal, rsp_timeout, req_ready}),
              64'b0000001);
        check("reset_mem_addr", 64'(mem_addr), 64'd0);
        check("reset_rsp_data", 64'(rsp_data), 64'd0);
        tick;
        reset = 1'b0;
        tick;
        mem_ready = 1'b1;
        tick;
        check("mem_ready_idle_ignored", 64'({busy, rsp_valid, mem_valid}), 64'd0);
        mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) run(vecs[i]);
        req_valid = 1'b1; req_funct3 = 3'b000; req_amo = 1'b0; req_addr = 32'h0000_A003;
        tick;
        req_valid = 1'b0;
        tick;
        check("mid_load_in_req", 64'({mem_valid, busy}), 64'b11);
        reset = 1'b1;
        #1;
        check("async_reset_drop", 64'({mem_valid, busy, rsp_valid}), 64'd0);
        tick;
        reset = 1'b0;
        tick;
        check("no_rsp_after_reset", 64'({rsp_valid, req_ready}), 64'b01);
        run('{3'b000, 1'b0, 32'h0000_A001, 32'h0000_7F00, 1, 32'h0000_007F, 3'b000});
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
